ahb_bus_arbiter: RTL
====================

Name: ahb_bus_arbiter

Overview:
- Shares the bridge's single AHB slave port between NUM_MST AHB masters.
- Uses round-robin arbitration and never breaks a burst or a locked sequence.
- Muxes the granted master's address/control onto the bridge and its HWDATA one cycle later, in the data phase.
- Sits between the AHB masters and the AHB-to-APB bridge top. Its HREADY input is the bridge's HREADYout.

Parameters:
- NUM_MST, 3, number of requesting masters (2..8).
- MW, 2, width of the master index; must satisfy 2**MW >= NUM_MST.
- DEF_MST, 0, default (parked) master when no requests are pending.

Ports:
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HBUSREQ  in  NUM_MST  per-master bus request.
- HLOCK  in  NUM_MST  per-master locked-transfer request.
- HTRANS_M  in  2*NUM_MST  packed per-master HTRANS; master i at bits [2i+1:2i].
- HADDR_M  in  32*NUM_MST  packed per-master address.
- HWRITE_M  in  NUM_MST  per-master write flag.
- HSIZE_M  in  3*NUM_MST  packed per-master size.
- HWDATA_M  in  32*NUM_MST  packed per-master write data.
- HREADY  in  1  transfer-complete from the bridge (HREADYout).
- HGRANT  out  NUM_MST  one-hot grant.
- HMASTER  out  MW  address-phase owner.
- HMASTLOCK  out  1  current address phase is locked.
- HADDR  out  32  muxed address to the bridge.
- HTRANS  out  2  muxed HTRANS to the bridge.
- HWRITE  out  1  muxed write flag.
- HSIZE  out  3  muxed size.
- HWDATA  out  32  muxed write data, selected by the data-phase owner.

Behaviour:
- All registers update only on the rising edge of HCLK, and only when HREADY=1, except during reset.
- Reset (HRESET=1 at an edge) overrides everything, including mid-burst or while waited:
  - HGRANT = one-hot(DEF_MST).
  - HMASTER = DEF_MST; data-phase owner = DEF_MST.
  - HMASTLOCK = 0.
  - Last-granted pointer = DEF_MST.
  - State = PARK.
- Encodings:
  - HTRANS: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
  - Muxed outputs are combinational selections by HMASTER (address/control) or by the data-phase owner (HWDATA).
  - When the parked master drives IDLE, HTRANS out is 00.
- FSM states:
  - PARK: no requests; DEF_MST granted.
  - OWN: a master holds the bus, unlocked.
  - LOCK: the owner asserted HLOCK with its grant.
- Arbitration point: an edge with HREADY=1 where the address-phase owner's HTRANS is IDLE or NONSEQ-as-last, i.e. its next transfer is not SEQ/BUSY. Implementation rule: re-arbitrate when the owner's HTRANS_M is not SEQ/BUSY and its HBUSREQ=0, or when its HTRANS_M is IDLE.
- Round-robin selection:
  - Search HBUSREQ starting at (last+1) mod NUM_MST.
  - The first requester wins; its HGRANT bit is set at that edge and last := winner.
  - No requester: grant DEF_MST, state PARK.
- Ownership pipeline:
  - HMASTER takes the HGRANT index at the next HREADY=1 edge (address-phase handover).
  - The data-phase owner takes the old HMASTER at the same edge, so HWDATA always follows the master whose address phase just completed.
- Burst protection: while the owner's HTRANS_M is SEQ or BUSY, HGRANT is held regardless of other requests.
- LOCK:
  - Entered when the granted master has HLOCK=1 at the arbitration point.
  - Grant is held until that master drops HLOCK and its HTRANS_M is IDLE, then arbitration proceeds normally.
  - HMASTLOCK registers the owner's HLOCK with HMASTER.
- Wait states: HREADY=0 freezes HGRANT, HMASTER, the data-phase owner, state and pointer, even if requests change.
- Simultaneous requests: the round-robin order is strict; no master wins twice while another requester waits through a full rotation.
- Owner index ≥ NUM_MST is unreachable; if it is ever decoded, output HTRANS = IDLE.

Test Plan:
- Reset with HBUSREQ=000 → HGRANT=001, HMASTER=0, HTRANS=00, HMASTLOCK=0. Hold 3 cycles: unchanged.
- HBUSREQ=110 from PARK, masters doing single NONSEQ writes with HREADY=1:
  - Grants go 010 → 100 → 010.
  - HMASTER lags HGRANT by one cycle.
  - HWDATA shows master 1's data (e.g. 0x1111_1111) the cycle after its address 0x0000_1000.
- Master 2 runs a 4-beat INCR (NONSEQ, SEQ×3) while master 0 requests:
  - HGRANT stays 100 through the 3rd SEQ address phase.
  - HGRANT changes to 001 only at the edge where the last beat issues.
- HREADY=0 for 2 cycles mid-burst while a new master requests → HGRANT, HMASTER, HADDR and HWDATA sources are frozen; progress resumes on HREADY=1.
- Master 1 with HLOCK=1 does 2 locked transfers, then IDLE with HLOCK=0:
  - HMASTLOCK=1 during both address phases.
  - No grant change until the IDLE.
  - Grant then passes to pending master 2.
- HRESET asserted mid-burst of master 2 → on the next edge HGRANT=001, HMASTER=0, state PARK, the HTRANS output reflects master 0 (IDLE).

Source files
------------

// File: rtl/ahb_bus_arbiter_if.sv
// Bus bundle between the AHB masters and the shared bridge slave port.
// The slave modport is the arbiter's view; the master modport is the
// requesting side (masters plus the bridge's HREADYout).
interface ahb_bus_arbiter_if #(
    parameter int NUM_MST = 3,
    parameter int MW      = 2
);
    logic [NUM_MST-1:0]    HBUSREQ;
    logic [NUM_MST-1:0]    HLOCK;
    logic [2*NUM_MST-1:0]  HTRANS_M;
    logic [32*NUM_MST-1:0] HADDR_M;
    logic [NUM_MST-1:0]    HWRITE_M;
    logic [3*NUM_MST-1:0]  HSIZE_M;
    logic [32*NUM_MST-1:0] HWDATA_M;
    logic                  HREADY;

    logic [NUM_MST-1:0]    HGRANT;
    logic [MW-1:0]         HMASTER;
    logic                  HMASTLOCK;
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [31:0]           HWDATA;

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS_M, HADDR_M, HWRITE_M, HSIZE_M, HWDATA_M, HREADY,
        output HGRANT, HMASTER, HMASTLOCK, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    modport master (
        output HBUSREQ, HLOCK, HTRANS_M, HADDR_M, HWRITE_M, HSIZE_M, HWDATA_M, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter sharing one bridge slave port among NUM_MST
// masters. Bursts and locked sequences are never broken; the granted
// master's address/control is muxed by HMASTER and its write data by the
// data-phase owner one cycle later.
module ahb_bus_arbiter #(
    parameter int NUM_MST = 3,
    parameter int MW      = 2,
    parameter int DEF_MST = 0
) (
    input logic              HCLK,
    input logic              HRESET,
    ahb_bus_arbiter_if.slave bus
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;

    state_t             state;
    logic [NUM_MST-1:0] grant;
    logic [MW-1:0]      gnt_idx;
    logic [MW-1:0]      hmaster;
    logic [MW-1:0]      downer;
    logic [MW-1:0]      last;
    logic               mastlock;

    logic [1:0]         own_trans;
    logic               own_req;
    logic [31:0]        mux_addr;
    logic               mux_write;
    logic [2:0]         mux_size;
    logic [31:0]        mux_wdata;
    logic [1:0]         gnt_trans;
    logic               gnt_lock;

    logic               found;
    logic [MW-1:0]      winner;
    logic               win_lock;
    logic [MW-1:0]      cand;
    logic               rearb;

    function automatic logic [NUM_MST-1:0] onehot(input logic [MW-1:0] idx);
        logic [NUM_MST-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_MST; i++) begin
            v[i] = (idx == MW'(i));
        end
        return v;
    endfunction

    // Select owner, grantee and data-phase signals; an index with no master decodes to IDLE/zero.
    always_comb begin
        own_trans = HT_IDLE;
        own_req   = 1'b0;
        mux_addr  = '0;
        mux_write = 1'b0;
        mux_size  = '0;
        mux_wdata = '0;
        gnt_trans = HT_IDLE;
        gnt_lock  = 1'b0;
        for (int unsigned i = 0; i < NUM_MST; i++) begin
            if (hmaster == MW'(i)) begin
                own_trans = bus.HTRANS_M[2*i +: 2];
                own_req   = bus.HBUSREQ[i];
                mux_addr  = bus.HADDR_M[32*i +: 32];
                mux_write = bus.HWRITE_M[i];
                mux_size  = bus.HSIZE_M[3*i +: 3];
            end
            if (gnt_idx == MW'(i)) begin
                gnt_trans = bus.HTRANS_M[2*i +: 2];
                gnt_lock  = bus.HLOCK[i];
            end
            if (downer == MW'(i)) begin
                mux_wdata = bus.HWDATA_M[32*i +: 32];
            end
        end
    end

    // Round-robin search: first requester after the last winner, wrapping.
    always_comb begin
        found    = 1'b0;
        winner   = MW'(DEF_MST);
        win_lock = 1'b0;
        cand     = last;
        for (int unsigned k = 0; k < NUM_MST; k++) begin
            cand = (cand >= MW'(NUM_MST - 1)) ? '0 : cand + 1'b1;
            for (int unsigned i = 0; i < NUM_MST; i++) begin
                if (!found && (cand == MW'(i)) && bus.HBUSREQ[i]) begin
                    found    = 1'b1;
                    winner   = cand;
                    win_lock = bus.HLOCK[i];
                end
            end
        end
    end

    // Arbitration point: locked grantee idle with lock dropped, or owner's burst finished.
    always_comb begin
        if (state == LOCK) begin
            rearb = !gnt_lock && (gnt_trans == HT_IDLE);
        end else begin
            rearb = (own_trans == HT_IDLE) || ((own_trans == HT_NONSEQ) && !own_req);
        end
    end

    // Grant FSM and ownership pipeline; everything holds while the bridge inserts waits.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= PARK;
            gnt_idx  <= MW'(DEF_MST);
            grant    <= onehot(MW'(DEF_MST));
            hmaster  <= MW'(DEF_MST);
            downer   <= MW'(DEF_MST);
            last     <= MW'(DEF_MST);
            mastlock <= 1'b0;
        end else if (bus.HREADY) begin
            downer   <= hmaster;
            hmaster  <= gnt_idx;
            mastlock <= gnt_lock;
            if (rearb) begin
                if (found) begin
                    gnt_idx <= winner;
                    grant   <= onehot(winner);
                    last    <= winner;
                    state   <= win_lock ? LOCK : OWN;
                end else begin
                    gnt_idx <= MW'(DEF_MST);
                    grant   <= onehot(MW'(DEF_MST));
                    state   <= PARK;
                end
            end
        end
    end

    assign bus.HGRANT    = grant;
    assign bus.HMASTER   = hmaster;
    assign bus.HMASTLOCK = mastlock;
    assign bus.HADDR     = mux_addr;
    assign bus.HTRANS    = own_trans;
    assign bus.HWRITE    = mux_write;
    assign bus.HSIZE     = mux_size;
    assign bus.HWDATA    = mux_wdata;

endmodule
